zuc_sched: RTL and testbench

- Scheduler for one shared ZUC keystream core, sitting between two session requesters and that core.
  - Requester 0: EEA3 confidentiality.
  - Requester 1: EIA3 integrity.
- Arbitrates requests round-robin, loads the winner's key, IV and length into the core, and pulses the core start.
- Buffers returned keystream words in a small FIFO that presents a valid/ready stream tagged with requester ID.
- Applies backpressure to the core and runs a stall watchdog.

---
 rtl/zuc_sched.sv | 148 ++++++++++++++
 tb/tb_zuc_sched.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zuc_sched.sv
// Round-robin scheduler for one shared ZUC core serving EEA3 (req 0) and EIA3 (req 1).
// Loads the winner's session into the core, buffers keystream words and guards against core stalls.
module zuc_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [255:0] req_key,
  input  logic [255:0] req_iv,
  input  logic [15:0]  req_len,
  output logic         core_start,
  output logic [127:0] core_k,
  output logic [127:0] core_iv,
  output logic [7:0]   core_L,
  output logic         core_hold,
  input  logic         core_z_valid,
  input  logic [31:0]  core_z,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [31:0]  ks_data,
  output logic         ks_id,
  output logic         ks_last,
  output logic         busy,
  output logic         err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            rr_ptr;
  logic            owner;
  logic [7:0]      word_cnt;
  logic [WW-1:0]   wd_cnt;
  logic [33:0]     mem [FIFO_DEPTH];
  logic [33:0]     head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_nxt;
  logic            grant_vld, grant, full, push, push_ok, pop;
  logic            is_last, wd_tick, wd_expire, overflow;
  logic [7:0]      sel_len;

  // rr_ptr names the requester favoured on a tie; it always points away from the last one served
  always_comb begin
    grant_vld = (state == IDLE) && (req_valid != 2'b00);
    grant     = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
    req_ready = 2'b00;
    if (grant_vld) req_ready = grant ? 2'b10 : 2'b01;
    sel_len   = grant ? req_len[15:8] : req_len[7:0];
  end

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = ks_valid && ks_ready;
  assign push      = (state == RUN) && core_z_valid;
  assign push_ok   = push && (!full || pop);
  assign overflow  = push && full && !pop;
  assign is_last   = (word_cnt == core_L - 8'd1);
  assign wd_tick   = (state == RUN) && !core_hold && !core_z_valid;
  assign wd_expire = wd_tick && (wd_cnt == WW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (grant_vld && sel_len != 8'd0) state_nxt = LOAD;
      LOAD:  state_nxt = RUN;
      RUN: begin
        if (wd_expire)             state_nxt = IDLE;
        else if (push && is_last)  state_nxt = DRAIN;
      end
      DRAIN: if (count == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A watchdog abort flushes the buffer so no partial session leaks downstream
  always_comb begin
    count_nxt = count;
    if (wd_expire)           count_nxt = '0;
    else if (push_ok && !pop) count_nxt = count + (AW+1)'(1);
    else if (!push_ok && pop) count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      core_k    <= '0;
      core_iv   <= '0;
      core_L    <= '0;
      word_cnt  <= '0;
      wd_cnt    <= '0;
      err       <= 1'b0;
      core_hold <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (grant_vld) begin
        rr_ptr  <= ~grant;
        owner   <= grant;
        core_k  <= grant ? req_key[255:128] : req_key[127:0];
        core_iv <= grant ? req_iv[255:128]  : req_iv[127:0];
        core_L  <= sel_len;
      end
      if (state == LOAD) begin
        word_cnt <= '0;
        wd_cnt   <= '0;
      end else if (state == RUN) begin
        if (push) word_cnt <= word_cnt + 8'd1;
        if (core_z_valid) wd_cnt <= '0;
        else if (wd_tick) wd_cnt <= wd_cnt + WW'(1);
      end
      if (wd_expire || overflow) err <= 1'b1;
      core_hold <= (count_nxt >= (AW+1)'(FIFO_DEPTH - 1));
      count     <= count_nxt;
      if (wd_expire) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {owner, is_last, core_z};
  end

  assign head       = mem[rd_ptr];
  assign ks_valid   = (count != '0);
  assign ks_data    = ks_valid ? head[31:0] : 32'd0;
  assign ks_last    = ks_valid & head[32];
  assign ks_id      = ks_valid & head[33];
  assign busy       = (state != IDLE);
  assign core_start = (state == LOAD);

endmodule

// File: tb/tb_zuc_sched.sv
// Directed self-checking bench for zuc_sched with a small behavioural core model.
module tb_zuc_sched;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_key;
  logic [255:0] req_iv;
  logic [15:0]  req_len;
  logic         core_start;
  logic [127:0] core_k;
  logic [127:0] core_iv;
  logic [7:0]   core_L;
  logic         core_hold;
  logic         core_z_valid;
  logic [31:0]  core_z;
  logic         ks_valid;
  logic         ks_ready;
  logic [31:0]  ks_data;
  logic         ks_id;
  logic         ks_last;
  logic         busy;
  logic         err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n_starts = 0;
  int n_zwords = 0;
  logic [31:0] q_data[$];
  logic        q_id[$];
  logic        q_last[$];

  localparam logic [127:0] KEY0 = {4{32'h5555_0000}};
  localparam logic [127:0] KEY1 = {4{32'hAAAA_1111}};
  localparam logic [127:0] IV0  = {4{32'h0F0F_0000}};
  localparam logic [127:0] IV1  = {4{32'hF0F0_1111}};

  zuc_sched #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_iv(req_iv), .req_len(req_len),
    .core_start(core_start), .core_k(core_k), .core_iv(core_iv), .core_L(core_L),
    .core_hold(core_hold), .core_z_valid(core_z_valid), .core_z(core_z),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
    .ks_id(ks_id), .ks_last(ks_last), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor: records every output handshake, core start and core word
  always @(negedge clk) begin
    if (ks_valid && ks_ready) begin
      q_data.push_back(ks_data);
      q_id.push_back(ks_id);
      q_last.push_back(ks_last);
    end
    if (core_start)   n_starts++;
    if (core_z_valid) n_zwords++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input logic [7:0] len, output bit ok);
    int cyc = 0;
    req_len   = (id == 1) ? {len, 8'd0} : {8'd0, len};
    req_valid = (id == 1) ? 2'b10 : 2'b01;
    #1;
    while (!req_ready[id] && cyc < 50) begin tick(); cyc++; end
    ok = req_ready[id];
    tick();
    req_valid = 2'b00;
  endtask

  task automatic wait_idle(output bit ok);
    int cyc = 0;
    while (busy && cyc < 300) begin tick(); cyc++; end
    ok = !busy;
  endtask

  // Core model: waits for start, emits words, honours core_hold one cycle late
  task automatic core_drive(input int n, input int stop_after, input logic [31:0] w0);
    int   sent = 0;
    int   cyc = 0;
    logic hold_prev;
    while (!core_start && cyc < 20) begin tick(); cyc++; end
    vec_cnt++;
    if (!core_start) begin
      err_cnt++;
      $display("[TB] FAIL core_start_wait: got %0b expected 1", core_start);
      return;
    end
    hold_prev = core_hold;
    cyc = 0;
    while (sent < n && sent < stop_after && cyc < 400) begin
      tick();
      cyc++;
      if (!hold_prev) begin
        core_z_valid = 1'b1;
        core_z       = w0 + 32'(sent);
        sent++;
      end else begin
        core_z_valid = 1'b0;
      end
      hold_prev = core_hold;
    end
    tick();
    core_z_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vec_cnt++;
    if ({ks_valid, ks_last, busy, err, core_hold, core_start, req_ready} !== 8'd0) begin
      err_cnt++;
      $display("[TB] FAIL reset_flags: got %b expected 00000000",
               {ks_valid, ks_last, busy, err, core_hold, core_start, req_ready});
    end
    vec_cnt++;
    if (core_k !== 128'd0 || core_iv !== 128'd0 || core_L !== 8'd0) begin
      err_cnt++;
      $display("[TB] FAIL reset_core_regs: got L=%0d k=%0h expected 0", core_L, core_k);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int qb = q_data.size();
    int sb = n_starts;
    bit ok;
    ks_ready  = 1'b1;
    req_len   = {8'd0, 8'd3};
    req_valid = 2'b01;
    #1;
    vec_cnt++;
    if (req_ready !== 2'b01) begin
      err_cnt++; $display("[TB] FAIL single_ready: got %b expected 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    vec_cnt++;
    if (core_start !== 1'b1 || core_L !== 8'd3 || core_k !== KEY0 || core_iv !== IV0 || busy !== 1'b1) begin
      err_cnt++;
      $display("[TB] FAIL single_load: got start=%b L=%0d busy=%b expected start=1 L=3 busy=1",
               core_start, core_L, busy);
    end
    core_drive(3, 99, 32'hC000_0000);
    wait_idle(ok);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("[TB] FAIL single_idle: got busy=%b expected 0", busy); end
    vec_cnt++;
    if (q_data.size() - qb !== 3 || n_starts - sb !== 1) begin
      err_cnt++;
      $display("[TB] FAIL single_counts: got words=%0d starts=%0d expected 3 and 1",
               q_data.size() - qb, n_starts - sb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vec_cnt++;
        if (q_data[qb+i] !== 32'hC000_0000 + 32'(i) || q_id[qb+i] !== 1'b0 || q_last[qb+i] !== (i == 2)) begin
          err_cnt++;
          $display("[TB] FAIL single_word%0d: got %h id=%b last=%b expected %h id=0 last=%b",
                   i, q_data[qb+i], q_id[qb+i], q_last[qb+i], 32'hC000_0000 + 32'(i), (i == 2));
        end
      end
    end
  endtask

  task automatic test_zero_length();
    int qb = q_data.size();
    int sb = n_starts;
    ks_ready  = 1'b1;
    req_len   = 16'd0;
    req_valid = 2'b10;
    #1;
    vec_cnt++;
    if (req_ready !== 2'b10) begin
      err_cnt++; $display("[TB] FAIL zero_ready: got %b expected 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL zero_busy: got %b expected 0", busy); end
    repeat (5) tick();
    vec_cnt++;
    if (n_starts != sb || q_data.size() != qb || ks_valid !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL zero_activity: got starts=%0d words=%0d ks_valid=%b expected 0 0 0",
               n_starts - sb, q_data.size() - qb, ks_valid);
    end
  endtask

  task automatic test_contention();
    int qb = q_data.size();
    int sb = n_starts;
    int cyc;
    bit ok;
    logic [31:0] exp_d  [6] = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hD0, 32'hD1};
    logic        exp_id [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ks_ready  = 1'b1;
    req_len   = {8'd2, 8'd2};
    req_valid = 2'b11;
    #1;
    vec_cnt++;
    if (req_ready !== 2'b01) begin
      err_cnt++; $display("[TB] FAIL cont_first_grant: got %b expected 01", req_ready);
    end
    tick();
    req_valid = 2'b10;
    #1;
    vec_cnt++;
    if (req_ready !== 2'b00) begin
      err_cnt++; $display("[TB] FAIL cont_no_overlap: got %b expected 00", req_ready);
    end
    core_drive(2, 99, 32'hA0);
    req_valid = 2'b11;
    cyc = 0;
    while (req_ready == 2'b00 && cyc < 50) begin tick(); cyc++; end
    vec_cnt++;
    if (req_ready !== 2'b10) begin
      err_cnt++; $display("[TB] FAIL cont_second_grant: got %b expected 10", req_ready);
    end
    if (req_ready != 2'b00) tick();
    req_valid = 2'b01;
    core_drive(2, 99, 32'hB0);
    cyc = 0;
    while (req_ready == 2'b00 && cyc < 50) begin tick(); cyc++; end
    vec_cnt++;
    if (req_ready !== 2'b01) begin
      err_cnt++; $display("[TB] FAIL cont_third_grant: got %b expected 01", req_ready);
    end
    if (req_ready != 2'b00) tick();
    req_valid = 2'b00;
    core_drive(2, 99, 32'hD0);
    wait_idle(ok);
    vec_cnt++;
    if (!ok || q_data.size() - qb !== 6 || n_starts - sb !== 3) begin
      err_cnt++;
      $display("[TB] FAIL cont_counts: got words=%0d starts=%0d idle=%b expected 6 3 1",
               q_data.size() - qb, n_starts - sb, ok);
    end else begin
      for (int i = 0; i < 6; i++) begin
        vec_cnt++;
        if (q_data[qb+i] !== exp_d[i] || q_id[qb+i] !== exp_id[i] || q_last[qb+i] !== (i % 2 == 1)) begin
          err_cnt++;
          $display("[TB] FAIL cont_word%0d: got %h id=%b last=%b expected %h id=%b last=%b",
                   i, q_data[qb+i], q_id[qb+i], q_last[qb+i], exp_d[i], exp_id[i], (i % 2 == 1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int qb = q_data.size();
    int zb = n_zwords;
    bit ok;
    ks_ready = 1'b0;
    issue(0, 8'd8, ok);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("[TB] FAIL bp_accept: got %b expected 1", ok); end
    fork
      core_drive(8, 99, 32'hE0);
      begin
        int cyc = 0;
        while (!core_hold && cyc < 50) begin tick(); cyc++; end
        vec_cnt++;
        if (!core_hold || n_zwords - zb !== 3) begin
          err_cnt++;
          $display("[TB] FAIL bp_hold_rise: got hold=%b words=%0d expected hold=1 words=3",
                   core_hold, n_zwords - zb);
        end
        repeat (5) tick();
        vec_cnt++;
        if (n_zwords - zb !== 4 || ks_valid !== 1'b1 || ks_data !== 32'hE0 || err !== 1'b0) begin
          err_cnt++;
          $display("[TB] FAIL bp_stalled: got words=%0d valid=%b data=%h err=%b expected 4 1 e0 0",
                   n_zwords - zb, ks_valid, ks_data, err);
        end
        ks_ready = 1'b1;
        wait_idle(ok);
      end
    join
    vec_cnt++;
    if (!ok || q_data.size() - qb !== 8 || err !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL bp_counts: got words=%0d err=%b idle=%b expected 8 0 1",
               q_data.size() - qb, err, ok);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vec_cnt++;
        if (q_data[qb+i] !== 32'hE0 + 32'(i) || q_id[qb+i] !== 1'b0 || q_last[qb+i] !== (i == 7)) begin
          err_cnt++;
          $display("[TB] FAIL bp_word%0d: got %h last=%b expected %h last=%b",
                   i, q_data[qb+i], q_last[qb+i], 32'hE0 + 32'(i), (i == 7));
        end
      end
    end
  endtask

  task automatic test_watchdog();
    int qb = q_data.size();
    bit ok;
    ks_ready = 1'b1;
    issue(0, 8'd4, ok);
    core_drive(4, 1, 32'hF0);
    repeat (14) tick();
    vec_cnt++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL wd_before: got err=%b busy=%b expected err=0 busy=1", err, busy);
    end
    tick();
    vec_cnt++;
    if (err !== 1'b1 || busy !== 1'b0 || ks_valid !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL wd_abort: got err=%b busy=%b valid=%b expected 1 0 0", err, busy, ks_valid);
    end
    vec_cnt++;
    if (q_data.size() - qb !== 1 || q_last[q_last.size()-1] !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL wd_words: got words=%0d expected 1 word without last", q_data.size() - qb);
    end
    qb = q_data.size();
    issue(1, 8'd2, ok);
    core_drive(2, 99, 32'h70);
    wait_idle(ok);
    vec_cnt++;
    if (!ok || q_data.size() - qb !== 2 || err !== 1'b1) begin
      err_cnt++;
      $display("[TB] FAIL wd_recover_counts: got words=%0d err=%b expected 2 1", q_data.size() - qb, err);
    end else begin
      vec_cnt++;
      if (q_data[qb] !== 32'h70 || q_data[qb+1] !== 32'h71 || q_id[qb+1] !== 1'b1 ||
          q_last[qb] !== 1'b0 || q_last[qb+1] !== 1'b1) begin
        err_cnt++;
        $display("[TB] FAIL wd_recover_words: got %h/%h last=%b%b expected 70/71 last=01",
                 q_data[qb], q_data[qb+1], q_last[qb], q_last[qb+1]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int qb = q_data.size();
    int lasts = 0;
    bit ok;
    ks_ready = 1'b1;
    issue(0, 8'd5, ok);
    core_drive(5, 2, 32'h90);
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({ks_valid, ks_last, busy, err, core_hold, core_start} !== 6'd0 || core_L !== 8'd0) begin
      err_cnt++;
      $display("[TB] FAIL mreset_outputs: got %b L=%0d expected 000000 L=0",
               {ks_valid, ks_last, busy, err, core_hold, core_start}, core_L);
    end
    for (int i = qb; i < q_data.size(); i++) if (q_last[i]) lasts++;
    vec_cnt++;
    if (lasts != 0) begin err_cnt++; $display("[TB] FAIL mreset_last: got %0d expected 0", lasts); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    qb = q_data.size();
    issue(0, 8'd3, ok);
    core_drive(3, 99, 32'h30);
    wait_idle(ok);
    vec_cnt++;
    if (!ok || q_data.size() - qb !== 3) begin
      err_cnt++; $display("[TB] FAIL mreset_after_count: got %0d expected 3", q_data.size() - qb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vec_cnt++;
        if (q_data[qb+i] !== 32'h30 + 32'(i) || q_last[qb+i] !== (i == 2)) begin
          err_cnt++;
          $display("[TB] FAIL mreset_after_word%0d: got %h last=%b expected %h last=%b",
                   i, q_data[qb+i], q_last[qb+i], 32'h30 + 32'(i), (i == 2));
        end
      end
    end
  endtask

  initial begin
    req_valid    = 2'b00;
    req_key      = {KEY1, KEY0};
    req_iv       = {IV1, IV0};
    req_len      = 16'd0;
    core_z_valid = 1'b0;
    core_z       = 32'd0;
    ks_ready     = 1'b0;
    test_reset();
    test_single();
    test_zero_length();
    test_contention();
    test_backpressure();
    test_watchdog();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
